// File: rtl/glow_io_bank.sv
// Memory-mapped GPIO bank: PORTS channels of WIDTH bits with OUT/DIR/IN/FLAG registers,
// shared CTRL/STAT registers, synchronised inputs and edge-capture interrupt.
module glow_io_bank #(
    parameter int unsigned PORTS = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ABITS = 5,
    parameter logic [23:0] BASE  = 24'hFFFF00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WAIT,
    input  logic [23:0]            daddr,
    input  logic [7:0]             ddata_i,
    output logic [7:0]             ddata_o,
    input  logic                   dwrite,
    input  logic [PORTS*WIDTH-1:0] io_i,
    output logic [PORTS*WIDTH-1:0] io_o,
    output logic [PORTS*WIDTH-1:0] io_oe,
    output logic                   irq
);

    localparam int unsigned NB       = PORTS * WIDTH;
    localparam int unsigned CTRL_OFF = 4 * PORTS;
    localparam int unsigned STAT_OFF = 4 * PORTS + 1;

    logic [NB-1:0]    out_q, dir_q, flag_q;
    logic [NB-1:0]    s1_q, s2_q, s3_q;
    logic [2:0]       ctrl_q;

    logic             hit_c, take_c, wr_c;
    logic [ABITS-1:0] off_c;
    logic [NB-1:0]    out_n, dir_n, flag_n, clr_c, rise_c, fall_c;
    logic [2:0]       ctrl_n;
    logic [7:0]       rdata_c;
    logic [PORTS-1:0] stat_c;

    // Address decode: a bus access is taken only on a window hit with no stall.
    assign hit_c  = (daddr[23:ABITS] == BASE[23:ABITS]);
    assign off_c  = daddr[ABITS-1:0];
    assign take_c = hit_c & ~WAIT;
    assign wr_c   = take_c & dwrite;

    assign io_o  = out_q;
    assign io_oe = dir_q;

    always_comb begin
        stat_c = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            stat_c[p] = |flag_q[p*WIDTH +: WIDTH];
        end
    end

    // Read mux; IN returns the synchronised pin regardless of direction.
    always_comb begin
        rdata_c = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (off_c == ABITS'(4*p + 0)) rdata_c[WIDTH-1:0] = out_q[p*WIDTH +: WIDTH];
            if (off_c == ABITS'(4*p + 1)) rdata_c[WIDTH-1:0] = dir_q[p*WIDTH +: WIDTH];
            if (off_c == ABITS'(4*p + 2)) rdata_c[WIDTH-1:0] = s2_q[p*WIDTH +: WIDTH];
            if (off_c == ABITS'(4*p + 3)) rdata_c[WIDTH-1:0] = flag_q[p*WIDTH +: WIDTH];
        end
        if (off_c == ABITS'(CTRL_OFF)) rdata_c[2:0] = ctrl_q;
        if (off_c == ABITS'(STAT_OFF)) rdata_c[PORTS-1:0] = stat_c;
    end

    // Register writes and flag update; a new capture beats a same-cycle W1C.
    always_comb begin
        out_n  = out_q;
        dir_n  = dir_q;
        ctrl_n = ctrl_q;
        clr_c  = '0;
        rise_c = s2_q & ~s3_q & {NB{ctrl_q[0]}};
        fall_c = ~s2_q & s3_q & {NB{ctrl_q[1]}};
        if (wr_c) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (off_c == ABITS'(4*p + 0)) out_n[p*WIDTH +: WIDTH] = ddata_i[WIDTH-1:0];
                if (off_c == ABITS'(4*p + 1)) dir_n[p*WIDTH +: WIDTH] = ddata_i[WIDTH-1:0];
                if (off_c == ABITS'(4*p + 3)) clr_c[p*WIDTH +: WIDTH] = ddata_i[WIDTH-1:0];
            end
            if (off_c == ABITS'(CTRL_OFF)) ctrl_n = ddata_i[2:0];
        end
        flag_n = (flag_q & ~clr_c) | rise_c | fall_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            flag_q  <= '0;
            ctrl_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            ddata_o <= '0;
            irq     <= 1'b0;
        end else begin
            out_q  <= out_n;
            dir_q  <= dir_n;
            flag_q <= flag_n;
            ctrl_q <= ctrl_n;
            s1_q   <= io_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            irq    <= ctrl_q[2] & (|flag_q);
            if (take_c) begin
                ddata_o <= rdata_c;
            end
        end
    end

endmodule

// File: tb/tb_glow_io_bank.sv
// Directed bench for glow_io_bank with a register-level reference model checked every cycle.
module tb_glow_io_bank;

    localparam int P = 2;
    localparam int W = 8;
    localparam logic [23:0] BASE = 24'hFFFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WAIT = 1'b0;
    logic        dwrite = 1'b0;
    logic [23:0] daddr = 24'h000100;
    logic [7:0]  ddata_i = 8'h00;
    logic [15:0] io_i = 16'h0000;
    logic [7:0]  ddata_o;
    logic [15:0] io_o, io_oe;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    glow_io_bank #(.PORTS(P), .WIDTH(W), .ABITS(5), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .WAIT(WAIT), .daddr(daddr), .ddata_i(ddata_i),
        .ddata_o(ddata_o), .dwrite(dwrite), .io_i(io_i), .io_o(io_o),
        .io_oe(io_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: registers by name, pin history as samples taken 1/2/3 edges ago.
    logic [7:0]  out_m [P];
    logic [7:0]  dir_m [P];
    logic [7:0]  flag_m[P];
    logic [2:0]  ctrl_m;
    logic [15:0] h1, h2, h3;
    logic        irq_m;
    logic [7:0]  rd_m;

    function automatic bit in_win(input logic [23:0] a);
        return (a >= BASE) && (a < BASE + 24'd32);
    endfunction

    function automatic int offs(input logic [23:0] a);
        return int'(a - BASE);
    endfunction

    function automatic bit wr_now();
        return in_win(daddr) && !WAIT && dwrite;
    endfunction

    function automatic logic [7:0] mread(input int o);
        logic [7:0] r;
        r = 8'h00;
        if (o < 4*P) begin
            case (o % 4)
                0: r = out_m[o/4];
                1: r = dir_m[o/4];
                2: r = h2[(o/4)*8 +: 8];
                default: r = flag_m[o/4];
            endcase
        end else if (o == 4*P) begin
            r = {5'b0, ctrl_m};
        end else if (o == 4*P + 1) begin
            r = {6'b0, |flag_m[1], |flag_m[0]};
        end
        return r;
    endfunction

    function automatic logic [7:0] flag_next(input int p);
        logic [7:0] f;
        bit set, clr;
        for (int b = 0; b < 8; b++) begin
            set = (ctrl_m[0] && h2[p*8+b] && !h3[p*8+b]) ||
                  (ctrl_m[1] && !h2[p*8+b] && h3[p*8+b]);
            clr = wr_now() && offs(daddr) == 4*p + 3 && ddata_i[b];
            f[b] = set ? 1'b1 : (clr ? 1'b0 : flag_m[p][b]);
        end
        return f;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < P; p++) begin
                out_m[p]  <= 8'h00;
                dir_m[p]  <= 8'h00;
                flag_m[p] <= 8'h00;
            end
            ctrl_m <= 3'b000;
            h1 <= 16'h0; h2 <= 16'h0; h3 <= 16'h0;
            irq_m <= 1'b0;
            rd_m  <= 8'h00;
        end else begin
            h1 <= io_i; h2 <= h1; h3 <= h2;
            irq_m <= ctrl_m[2] && ((flag_m[0] | flag_m[1]) != 8'h00);
            if (in_win(daddr) && !WAIT) rd_m <= mread(offs(daddr));
            for (int p = 0; p < P; p++) flag_m[p] <= flag_next(p);
            if (wr_now()) begin
                if (offs(daddr) < 4*P && offs(daddr) % 4 == 0) out_m[offs(daddr)/4] <= ddata_i;
                if (offs(daddr) < 4*P && offs(daddr) % 4 == 1) dir_m[offs(daddr)/4] <= ddata_i;
                if (offs(daddr) == 4*P) ctrl_m <= ddata_i[2:0];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        check("io_o", 32'(io_o), 32'({out_m[1], out_m[0]}));
        check("io_oe", 32'(io_oe), 32'({dir_m[1], dir_m[0]}));
        check("irq", 32'(irq), 32'(irq_m));
        check("ddata_o", 32'(ddata_o), 32'(rd_m));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic bus(input logic [23:0] a, input logic [7:0] d, input logic we, input logic w);
        daddr = a; ddata_i = d; dwrite = we; WAIT = w;
        tick();
        daddr = 24'h000100; ddata_i = 8'h00; dwrite = 1'b0; WAIT = 1'b0;
    endtask

    task automatic wr(input int o, input logic [7:0] d);
        bus(BASE + 24'(o), d, 1'b1, 1'b0);
    endtask

    task automatic rd(input int o, input logic [7:0] exp, input string nm);
        bus(BASE + 24'(o), 8'h00, 1'b0, 1'b0);
        check(nm, 32'(ddata_o), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_io_o", 32'(io_o), 32'h0);
        check("rst_io_oe", 32'(io_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        for (int o = 0; o < 4*P + 2; o++) rd(o, 8'h00, "rst_read");

        // Output and direction registers.
        wr(0, 8'hA5);
        check("out0_now", 32'(io_o[7:0]), 32'hA5);
        wr(1, 8'h0F);
        check("dir0_now", 32'(io_oe[7:0]), 32'h0F);
        wr(4, 8'h3C);
        check("out1_now", 32'(io_o[15:8]), 32'h3C);
        rd(0, 8'hA5, "rd_out0");
        rd(1, 8'h0F, "rd_dir0");
        rd(4, 8'h3C, "rd_out1");
        bus(BASE, 8'h11, 1'b1, 1'b1);
        check("wait_write", 32'(io_o[7:0]), 32'hA5);
        wr(5, 8'h77);
        rd(5, 8'h77, "raw_dir1");
        check("dir1_pins", 32'(io_oe[15:8]), 32'h77);

        // Rising capture on bit 3 with irq enabled.
        wr(8, 8'h05);
        io_i = 16'h0008;
        repeat (3) tick();
        check("irq_before", 32'(irq), 32'h0);
        rd(3, 8'h08, "flag0_rise");
        check("irq_after", 32'(irq), 32'h1);
        rd(9, 8'h01, "stat");
        rd(2, 8'h08, "in0");
        rd(8, 8'h05, "ctrl");

        // W1C clear, then a falling edge with fall capture disabled.
        wr(3, 8'h08);
        check("irq_at_clear", 32'(irq), 32'h1);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        rd(3, 8'h00, "flag0_cleared");
        io_i = 16'h0000;
        repeat (4) tick();
        rd(3, 8'h00, "no_fall_flag");
        check("irq_no_fall", 32'(irq), 32'h0);

        // Same-cycle set of bit 3 and W1C of bits 0 and 3.
        io_i = 16'h0001;
        repeat (3) tick();
        io_i = 16'h0009;
        tick();
        tick();
        wr(3, 8'h09);
        check("irq_collide", 32'(irq), 32'h1);
        rd(3, 8'h08, "set_wins");
        check("irq_set_wins", 32'(irq), 32'h1);
        check("model_flag0", 32'(flag_m[0]), 32'h08);

        // Irq disable keeps flags.
        wr(8, 8'h01);
        tick();
        check("irq_disabled", 32'(irq), 32'h0);
        rd(3, 8'h08, "flag_retained");
        wr(8, 8'h05);
        tick();
        tick();
        check("irq_reenabled", 32'(irq), 32'h1);

        // Unmapped and out-of-window accesses.
        bus(BASE + 24'h1F, 8'hFF, 1'b1, 1'b0);
        bus(24'h00FF00, 8'hFF, 1'b1, 1'b0);
        check("no_stray_write", 32'(io_o), 32'h3CA5);
        rd(31, 8'h00, "rd_unmapped_1f");
        rd(10, 8'h00, "rd_unmapped_0a");
        rd(0, 8'hA5, "rd_out0_again");
        bus(24'h00FF00, 8'h00, 1'b0, 1'b0);
        check("hold_nonhit", 32'(ddata_o), 32'hA5);
        bus(BASE + 24'd1, 8'h00, 1'b0, 1'b1);
        check("hold_wait", 32'(ddata_o), 32'hA5);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_io_o", 32'(io_o), 32'h0);
        check("arst_io_oe", 32'(io_oe), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_ddata", 32'(ddata_o), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rd(3, 8'h00, "flag_after_rst");
        rd(8, 8'h00, "ctrl_after_rst");
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
